// File: rtl/mc_maindec_if.sv
// mc_maindec_if - control bus between the multicycle main decoder and the
// datapath.
//
// Decoder inputs:  opcode (IR[31:26]), functi (IR[5:0]), mem_ready.
// Decoder outputs: PC/IR write enables, memory strobes, mux selects,
//                  register-file write controls, illegal flag, and the
//                  instr_count / cycle_count performance counters.
//
// Modports:
//   master - the decoder (drives the control signals).
//   slave  - the datapath/memory side (drives opcode, functi, mem_ready).
interface mc_maindec_if #(
    parameter int CNT_WIDTH = 32
);
    logic [5:0]           opcode;
    logic [5:0]           functi;
    logic                 mem_ready;

    logic                 pc_write;
    logic                 pc_write_cond;
    logic                 iord;
    logic                 ir_write;
    logic                 memory_write;
    logic [1:0]           memory_to_register;
    logic [1:0]           register_destination;
    logic                 register_write;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_operation;
    logic [1:0]           pc_source;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] instr_count;
    logic [CNT_WIDTH-1:0] cycle_count;

    modport master (
        input  opcode, functi, mem_ready,
        output pc_write, pc_write_cond, iord, ir_write, memory_write,
               memory_to_register, register_destination, register_write,
               alu_src_a, alu_src_b, alu_operation, pc_source, illegal,
               instr_count, cycle_count
    );

    modport slave (
        output opcode, functi, mem_ready,
        input  pc_write, pc_write_cond, iord, ir_write, memory_write,
               memory_to_register, register_destination, register_write,
               alu_src_a, alu_src_b, alu_operation, pc_source, illegal,
               instr_count, cycle_count
    );
endinterface

// File: rtl/mc_maindec.sv
// mc_maindec - multicycle main decoder for the 32-bit MIPS-style CPU.
//
// Registered Moore FSM that sequences each instruction over 3-5 cycles
// (FETCH, DECODE, then an opcode-specific path) and stretches FETCH, MEMRD
// and MEMWR until mem_ready. Drives every datapath control signal.
//
// Ports:
//   clk   - single clock, rising edge.
//   reset - asynchronous, active-low reset.
//   bus   - mc_maindec_if.master: opcode/functi/mem_ready in, controls and
//           performance counters out.
//
// Build option:
//   MC_MAINDEC_PERF_EN - when defined, builds cycle_count (active non-TRAP
//   cycles) and instr_count (retired instructions). When undefined both
//   counters read as constant 0 and no counter flops exist.
module mc_maindec #(
    parameter int n         = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mc_maindec_if.master  bus
);

    // The datapath width only has to be wide enough for a MIPS word.
    if (n < 32) begin : g_n_chk
        $error("mc_maindec: n must be at least 32");
    end

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b000011;
    localparam logic [5:0] OP_SUBI  = 6'b000100;
    localparam logic [5:0] OP_BEQ   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000111;
    localparam logic [5:0] OP_JAL   = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b001001;
    localparam logic [5:0] FN_JR    = 6'b000111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_IMMEX,
        S_IMMWB,
        S_BRANCH,
        S_JUMP,
        S_JR,
        S_JAL,
        S_TRAP
    } state_t;

    state_t state_q, state_d;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:        state_d = (bus.functi == FN_JR) ? S_JR : S_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_ADDI, OP_SUBI: state_d = S_IMMEX;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_JAL:          state_d = S_JAL;
                    default:         state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB,
            S_BRANCH, S_JUMP, S_JR, S_JAL: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;  // only reset leaves TRAP
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode. Everything is forced low while reset is held, so the
    // FETCH strobes (which follow mem_ready) cannot fire during reset.
    always_comb begin
        bus.pc_write             = 1'b0;
        bus.pc_write_cond        = 1'b0;
        bus.iord                 = 1'b0;
        bus.ir_write             = 1'b0;
        bus.memory_write         = 1'b0;
        bus.memory_to_register   = 2'b00;
        bus.register_destination = 2'b00;
        bus.register_write       = 1'b0;
        bus.alu_src_a            = 1'b0;
        bus.alu_src_b            = 2'b00;
        bus.alu_operation        = 2'b00;
        bus.pc_source            = 2'b00;
        bus.illegal              = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                // Branch target computed speculatively while decoding.
                S_DECODE: bus.alu_src_b = 2'b11;
                S_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEMRD: bus.iord = 1'b1;
                S_MEMWB: begin
                    bus.register_write     = 1'b1;
                    bus.memory_to_register = 2'b01;
                end
                S_MEMWR: begin
                    bus.iord         = 1'b1;
                    bus.memory_write = 1'b1;
                end
                S_EXEC: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_operation = 2'b10;
                end
                S_ALUWB: begin
                    bus.register_write       = 1'b1;
                    bus.register_destination = 2'b01;
                end
                S_IMMEX: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_src_b     = 2'b10;
                    bus.alu_operation = (bus.opcode == OP_SUBI) ? 2'b01 : 2'b00;
                end
                S_IMMWB: bus.register_write = 1'b1;
                S_BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    bus.alu_operation = (bus.opcode == OP_BNE) ? 2'b11 : 2'b01;
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b10;
                end
                S_JR: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = 2'b11;
                end
                S_JAL: begin
                    bus.pc_write             = 1'b1;
                    bus.pc_source            = 2'b10;
                    bus.register_write       = 1'b1;
                    bus.register_destination = 2'b10;
                    bus.memory_to_register   = 2'b10;
                end
                S_TRAP:  bus.illegal = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_MAINDEC_PERF_EN
    logic [CNT_WIDTH-1:0] instr_q;
    logic [CNT_WIDTH-1:0] cycle_q;
    logic                 retire;

    // Only final states ever step back to FETCH, so any such transition
    // retires an instruction.
    assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_q <= cycle_q + 1'b1;
            if (retire)            instr_q <= instr_q + 1'b1;
        end
    end

    assign bus.instr_count = instr_q;
    assign bus.cycle_count = cycle_q;
`else
    assign bus.instr_count = '0;
    assign bus.cycle_count = '0;
`endif

endmodule
